plus_dma_sched: RTL
===================

Name: plus_dma_sched

Overview:
- Three-channel sound-DMA sequencer for Plus mode.
- Once per scan line it walks the active channels in fixed order 0→1→2.
- For each channel it fetches one 16-bit instruction from RAM through a shared memory-request port and executes it.
- LOAD instructions are forwarded to the PSG register-write port. Other instructions manage pause, repeat-loop, interrupt and stop state.

Parameters:
- ADDR_W, 16: width of DMA byte addresses; instructions are word-aligned.
- PAUSE_W, 12: width of the PAUSE count field and the per-channel pause counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- line_strobe  in  1  one-clk pulse at each scan-line start (rising HSYNC, synchronised upstream).
- ch_start  in  3  per-channel pulse: load that channel's address from addr_din, clear its pause/loop state, set it active.
- ch_stop  in  3  per-channel pulse: clear active.
- addr_din  in  ADDR_W  start address for ch_start; bit 0 is ignored (forced 0).
- mem_req  out  1  memory read request; held until mem_ack.
- mem_addr  out  ADDR_W  word address of the fetch; stable while mem_req is high.
- mem_ack  in  1  one-clk pulse; mem_din is valid in the same cycle.
- mem_din  in  16  instruction word.
- psg_wr  out  1  PSG register-write request; held until psg_ack.
- psg_reg  out  4  PSG register index.
- psg_data  out  8  PSG data.
- psg_ack  in  1  one-clk accept pulse.
- int_req  out  3  per-channel sticky interrupt flags.
- int_clr  in  3  clears the matching int_req bit.
- ch_active  out  3  channel-running status.
- busy  out  1  high whenever the sequencer is not in IDLE.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. All channel addresses, pause counters, loop counters and loop addresses are 0. The line_pend flag is 0.
- FSM states:
  - IDLE: on line_strobe or line_pend, set ch=0, clear line_pend, go to SEL.
  - SEL: if channel ch is inactive, skip it. If its pause counter is nonzero, decrement it and skip. Otherwise go to FETCH. After ch=2 is handled, return to IDLE.
  - FETCH: assert mem_req with mem_addr = channel address. On mem_ack, latch mem_din, advance the address by 2 (wraps modulo 2^ADDR_W), drop mem_req, go to EXEC.
  - EXEC: decode the latched word (one clk).
  - PSGW: hold psg_wr until psg_ack, then advance ch.
- Decode of the latched instruction word:
  - 0RDD (bits 15:12=0): LOAD. psg_reg=[11:8], psg_data=[7:0]; go to PSGW.
  - 1nnn: PAUSE. pause counter ← n·(presc+1)−1 when n≠0; n=0 is a NOP. The channel executes nothing further until the counter reaches 0.
  - 2nnn: REPEAT. loop counter ← n; loop address ← current (already advanced) address.
  - 4xxx: control. Bits may combine and are applied in order LOOP, INT, STOP:
    - bit0 LOOP: if loop counter ≠0, decrement it and jump to the loop address; otherwise fall through.
    - bit4 INT: set int_req[ch].
    - bit5 STOP: clear ch_active[ch].
  - Any other opcode: NOP.
- Per-line limit: at most one instruction executes per channel per line.
- Strobe while busy: line_strobe arriving while busy sets line_pend. A second strobe while line_pend is already set is dropped, so at most one line is pending.
- ch_stop on the channel in FETCH: the memory handshake completes (mem_req is never withdrawn before mem_ack), but the word is discarded and the address is not advanced.
- ch_stop on the channel in PSGW: the PSG write completes.
- ch_start on an active channel: restarts it at the new address from the next line.
- ch_start and ch_stop in the same clk for the same channel: stop wins.
- int_clr and INT set in the same clk: set wins.
- Reset asserted mid-transaction: mem_req and psg_wr drop immediately.
- Latency: strobe → first mem_req = 2 clk when channel 0 is ready. mem_ack → psg_wr = 2 clk.

Optional Feature:
- Macro: PLUS_DMA_PRESCALE_EN.
- When defined:
  - Adds input presc[23:0] (8 bits per channel, channel 0 in [7:0]).
  - PAUSE loads n·(presc+1)−1, computed in PAUSE_W+8 bits. The pause counter widens to PAUSE_W+8 bits.
- When undefined:
  - No presc port; presc is treated as 0.
  - The pause counter stays PAUSE_W bits and loads n−1.

Test Plan:
- Start ch0 at 0x0100 with word 0x0742 there; pulse line_strobe → one mem_req @0x0100, then psg_wr reg=7 data=0x42; ch0 address becomes 0x0102.
- ch0 executes PAUSE 3 (0x1003, presc=0) → the next 2 strobes produce no fetch; the 3rd strobe fetches from 0x0102.
- REPEAT 2 at 0x0200, then LOAD at 0x0202 and LOOP at 0x0204 → the LOAD executes 3 times in total, then the fetch continues at 0x0206.
- All three channels active with 0x4030 (INT|STOP) → one strobe gives fetches in order ch0, ch1, ch2; int_req=3'b111 and ch_active=0. int_clr=3'b010 leaves int_req=3'b101.
- Strobe, then 2 further strobes while busy (mem_ack delayed 50 clk) → exactly 2 line passes run; the extra strobe is dropped.
- Start at 0xFFFE → the next fetch is at 0x0000. ch_stop during FETCH → handshake completes, no psg_wr, ch_active cleared.

Source files
------------

// File: rtl/plus_dma_sched.sv
// plus_dma_sched: three-channel Plus-mode sound-DMA sequencer.
// Optional macro PLUS_DMA_PRESCALE_EN adds per-channel PAUSE prescale.
module plus_dma_sched #(
  parameter int ADDR_W  = 16,
  parameter int PAUSE_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_strobe,
  input  logic [2:0]        ch_start,
  input  logic [2:0]        ch_stop,
  input  logic [ADDR_W-1:0] addr_din,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_din,
  output logic              psg_wr,
  output logic [3:0]        psg_reg,
  output logic [7:0]        psg_data,
  input  logic              psg_ack,
  output logic [2:0]        int_req,
  input  logic [2:0]        int_clr,
  output logic [2:0]        ch_active,
`ifdef PLUS_DMA_PRESCALE_EN
  input  logic [23:0]       presc,
`endif
  output logic              busy
);

`ifdef PLUS_DMA_PRESCALE_EN
  localparam int PC_W = PAUSE_W + 8;
`else
  localparam int PC_W = PAUSE_W;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_FETCH,
    S_EXEC,
    S_PSGW
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        ch_q, ch_d;
  logic              pend_q, pend_d;
  logic              kill_q, kill_d;
  logic [15:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [3:0]        preg_q, preg_d;
  logic [7:0]        pdat_q, pdat_d;
  logic [2:0]        act_q, act_d;
  logic [2:0]        int_q, int_d;

  logic [ADDR_W-1:0] addr_q  [3];
  logic [ADDR_W-1:0] addr_d  [3];
  logic [PC_W-1:0]   pause_q [3];
  logic [PC_W-1:0]   pause_d [3];
  logic [11:0]       lcnt_q  [3];
  logic [11:0]       lcnt_d  [3];
  logic [ADDR_W-1:0] lad_q   [3];
  logic [ADDR_W-1:0] lad_d   [3];

  logic              adv;
  logic              hit;
  logic [2:0]        int_set;
  logic [2:0]        stop_ex;
  logic [PC_W-1:0]   pload;

  // Pause reload value: n*(presc+1)-1 for the current channel
`ifdef PLUS_DMA_PRESCALE_EN
  logic [7:0] presc_ch;
  always_comb begin
    presc_ch = presc[{ch_q, 3'b000} +: 8];
    pload    = PC_W'(ir_q[11:0])
             * (PC_W'(presc_ch) + PC_W'(1))
             - PC_W'(1);
  end
`else
  always_comb begin
    pload = PC_W'(ir_q[11:0]) - PC_W'(1);
  end
`endif

  assign mem_req   = (state_q == S_FETCH);
  assign psg_wr    = (state_q == S_PSGW);
  assign busy      = (state_q != S_IDLE);
  assign mem_addr  = faddr_q;
  assign psg_reg   = preg_q;
  assign psg_data  = pdat_q;
  assign int_req   = int_q;
  assign ch_active = act_q;

  // Next-state logic for the sequencer and per-channel state
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pend_d  = pend_q;
    kill_d  = kill_q;
    ir_d    = ir_q;
    faddr_d = faddr_q;
    preg_d  = preg_q;
    pdat_d  = pdat_q;
    for (int i = 0; i < 3; i++) begin
      addr_d[i]  = addr_q[i];
      pause_d[i] = pause_q[i];
      lcnt_d[i]  = lcnt_q[i];
      lad_d[i]   = lad_q[i];
    end
    int_set = '0;
    stop_ex = '0;
    adv     = 1'b0;
    hit     = ch_start[ch_q] | ch_stop[ch_q];

    // only one line may queue behind the running pass
    if (state_q != S_IDLE && line_strobe)
      pend_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (line_strobe || pend_q) begin
          ch_d    = 2'd0;
          pend_d  = 1'b0;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        if (!act_q[ch_q]) begin
          adv = 1'b1;
        end else if (pause_q[ch_q] != '0) begin
          pause_d[ch_q] = pause_q[ch_q] - PC_W'(1);
          adv = 1'b1;
        end else begin
          faddr_d = addr_q[ch_q];
          kill_d  = hit;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // a stop/restart mid-fetch lets the read finish, then drops it
        if (hit)
          kill_d = 1'b1;
        if (mem_ack) begin
          if (kill_q || hit) begin
            adv = 1'b1;
          end else begin
            ir_d          = mem_din;
            addr_d[ch_q]  = faddr_q + ADDR_W'(2);
            state_d       = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        adv = 1'b1;
        unique case (1'b1)
          (ir_q[15:12] == 4'h0): begin
            preg_d  = ir_q[11:8];
            pdat_d  = ir_q[7:0];
            adv     = 1'b0;
            state_d = S_PSGW;
          end
          (ir_q[15:12] == 4'h1): begin
            if (ir_q[11:0] != 12'd0)
              pause_d[ch_q] = pload;
          end
          (ir_q[15:12] == 4'h2): begin
            lcnt_d[ch_q] = ir_q[11:0];
            lad_d[ch_q]  = addr_q[ch_q];
          end
          (ir_q[15:12] == 4'h4): begin
            if (ir_q[0] && lcnt_q[ch_q] != 12'd0) begin
              lcnt_d[ch_q] = lcnt_q[ch_q] - 12'd1;
              addr_d[ch_q] = lad_q[ch_q];
            end
            int_set[ch_q] = ir_q[4];
            stop_ex[ch_q] = ir_q[5];
          end
          default: ;
        endcase
      end
      S_PSGW: begin
        if (psg_ack)
          adv = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (ch_q == 2'd2) begin
        state_d = S_IDLE;
      end else begin
        ch_d    = ch_q + 2'd1;
        state_d = S_SEL;
      end
    end

    // host start/stop override whatever the sequencer did this clk
    for (int i = 0; i < 3; i++) begin
      if (ch_start[i]) begin
        addr_d[i]  = addr_din & ~ADDR_W'(1);
        pause_d[i] = '0;
        lcnt_d[i]  = '0;
        lad_d[i]   = '0;
      end
      if (ch_stop[i])
        act_d[i] = 1'b0;
      else if (ch_start[i])
        act_d[i] = 1'b1;
      else if (stop_ex[i])
        act_d[i] = 1'b0;
      else
        act_d[i] = act_q[i];
    end

    int_d = (int_q & ~int_clr) | int_set;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      pend_q  <= 1'b0;
      kill_q  <= 1'b0;
      ir_q    <= '0;
      faddr_q <= '0;
      preg_q  <= '0;
      pdat_q  <= '0;
      act_q   <= '0;
      int_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        addr_q[i]  <= '0;
        pause_q[i] <= '0;
        lcnt_q[i]  <= '0;
        lad_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      pend_q  <= pend_d;
      kill_q  <= kill_d;
      ir_q    <= ir_d;
      faddr_q <= faddr_d;
      preg_q  <= preg_d;
      pdat_q  <= pdat_d;
      act_q   <= act_d;
      int_q   <= int_d;
      for (int i = 0; i < 3; i++) begin
        addr_q[i]  <= addr_d[i];
        pause_q[i] <= pause_d[i];
        lcnt_q[i]  <= lcnt_d[i];
        lad_q[i]   <= lad_d[i];
      end
    end
  end

endmodule
